// File: rtl/dec139_rr_arbiter.sv
// Round-robin arbiter driving one half of a 74x139 decoder (G/A/B) so Y[n] is the grant strobe.
// Select lines only move while G is high; each grant is capped at HOLD_MAX cycles.
//   state | meaning
//   IDLE  | no grant, G=1, looking for a winner
//   SETUP | select lines set to winner, G still 1
//   GRANT | G=0, holding grant, counting hold cycles
//   GAP   | G=1, selects held, break-before-make
module dec139_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic       G,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic [1:0] gnt_id,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             g_q, g_d;
  logic             busy_q;
  logic             timeout_q, timeout_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       done_hit, req_hit, limit_hit;

  // Scan starts just after the previous winner and wraps through the 2-bit index.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign done_hit  = done[sel_q];
  assign req_hit   = req[sel_q];
  assign limit_hit = (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    g_d       = g_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = winner;
          last_d  = winner;
          state_d = SETUP;
        end
      end
      SETUP: begin
        g_d     = 1'b0;
        cnt_d   = '0;
        state_d = GRANT;
      end
      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_hit || !req_hit || limit_hit) begin
          g_d       = 1'b1;
          state_d   = GAP;
          // Only a pure hold-limit release is reported; done takes precedence.
          timeout_d = limit_hit && !done_hit && req_hit;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      g_q       <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      busy_q    <= (state_d != IDLE);
      timeout_q <= timeout_d;
    end
  end

  assign G       = g_q;
  assign A       = sel_q[0];
  assign B       = sel_q[1];
  assign gnt_id  = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
